switch_scan_ctrl: RTL and testbench

SWITCH_SCAN_CTRL -- requirements
Module: switch_scan_ctrl

---
 rtl/switch_scan_ctrl_pkg.sv | 45 ++++
 rtl/switch_scan_ctrl_tick.sv | 37 +++
 rtl/switch_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_switch_scan_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_scan_ctrl_pkg.sv
// Shared constants and register-read helpers for the switch scanner.
package switch_scan_ctrl_pkg;

    localparam int DEFAULT_SAMPLE_DIV = 100000;
    localparam int DEFAULT_STABLE_CNT = 4;
    localparam int SW_W               = 24;
    localparam int REG_W              = 16;

    localparam logic [1:0] ADDR_STAB_LO = 2'b00;
    localparam logic [1:0] ADDR_CHG_LO  = 2'b01;
    localparam logic [1:0] ADDR_STAB_HI = 2'b10;
    localparam logic [1:0] ADDR_CTRL_HI = 2'b11;

    function automatic logic [REG_W-1:0] reg_read(
        input logic [1:0]      addr,
        input logic [SW_W-1:0] stable,
        input logic [SW_W-1:0] chg,
        input logic            irq_en
    );
        logic [REG_W-1:0] data;
        case (addr)
            ADDR_STAB_LO: data = stable[15:0];
            ADDR_STAB_HI: data = {8'h00, stable[23:16]};
            ADDR_CHG_LO:  data = chg[15:0];
            ADDR_CTRL_HI: data = {irq_en, 7'b0000000, chg[23:16]};
            default:      data = 16'h0000;
        endcase
        return data;
    endfunction

    // Write-1-to-clear mask for the change flags addressed by a CPU write.
    function automatic logic [SW_W-1:0] chg_clear_mask(
        input logic [1:0]       addr,
        input logic [REG_W-1:0] wdata
    );
        logic [SW_W-1:0] mask;
        case (addr)
            ADDR_CHG_LO:  mask = {8'h00, wdata};
            ADDR_CTRL_HI: mask = {wdata[7:0], 16'h0000};
            default:      mask = 24'h000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/switch_scan_ctrl_tick.sv
// Sample-rate prescaler: one-cycle tick while the counter sits at DIV-1.
module tick_gen
    import switch_scan_ctrl_pkg::*;
#(
    parameter int DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Free-running counter; tick is registered one count early so it lines up with LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ONE;
            end
            tick_r <= (cnt_r == PRE_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/switch_scan_ctrl.sv
// Board-switch scanner: synchroniser, per-tick debounce, change flags and CPU register file.
module switch_scan_ctrl
    import switch_scan_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
    input  logic              scanclk,
    input  logic              scanrst,
    input  logic [SW_W-1:0]   switch_raw,
    input  logic              scanctl,
    input  logic              scanread,
    input  logic              scanwrite,
    input  logic [1:0]        scanaddr,
    input  logic [REG_W-1:0]  scanwdata,
    output logic [REG_W-1:0]  scanrdata,
    output logic              scan_irq
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT - 1);

    logic [SW_W-1:0]  sync_meta_r;
    logic [SW_W-1:0]  sync_r;
    logic [SW_W-1:0]  cand_r;
    logic [SW_W-1:0]  stable_r;
    logic [SW_W-1:0]  chg_r;
    logic [3:0]       stab_cnt_r;
    logic             irq_en_r;
    logic [REG_W-1:0] rdata_r;

    logic             tick_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             accept_s;
    logic [SW_W-1:0]  cand_nxt_s;
    logic [3:0]       cnt_nxt_s;
    logic [SW_W-1:0]  stable_nxt_s;
    logic [SW_W-1:0]  chg_set_s;
    logic [SW_W-1:0]  chg_clr_s;
    logic [SW_W-1:0]  chg_nxt_s;
    logic             irq_en_nxt_s;

    tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk  (scanclk),
        .rst  (scanrst),
        .tick (tick_s)
    );

    assign wr_en_s = scanctl & scanwrite;
    assign rd_en_s = scanctl & scanread;

    // Debounce decision and register-file next state; a new change flag beats a same-cycle clear.
    always_comb begin
        cand_nxt_s   = cand_r;
        cnt_nxt_s    = stab_cnt_r;
        accept_s     = 1'b0;
        if (tick_s) begin
            if (sync_r != cand_r) begin
                cand_nxt_s = sync_r;
                cnt_nxt_s  = 4'd0;
            end else if (stab_cnt_r == CNT_MAX) begin
                accept_s = (cand_r != stable_r);
            end else begin
                cnt_nxt_s = stab_cnt_r + 4'd1;
            end
        end else begin
            cand_nxt_s = cand_r;
        end

        if (accept_s) begin
            stable_nxt_s = cand_r;
            chg_set_s    = cand_r ^ stable_r;
        end else begin
            stable_nxt_s = stable_r;
            chg_set_s    = 24'h000000;
        end

        if (wr_en_s) begin
            chg_clr_s = chg_clear_mask(scanaddr, scanwdata);
        end else begin
            chg_clr_s = 24'h000000;
        end

        if (wr_en_s && (scanaddr == ADDR_CTRL_HI)) begin
            irq_en_nxt_s = scanwdata[15];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end

        chg_nxt_s = (chg_r & ~chg_clr_s) | chg_set_s;
    end

    // Synchroniser, debounce state and CPU-visible registers.
    always_ff @(posedge scanclk or posedge scanrst) begin
        if (scanrst) begin
            sync_meta_r <= 24'h000000;
            sync_r      <= 24'h000000;
            cand_r      <= 24'h000000;
            stable_r    <= 24'h000000;
            chg_r       <= 24'h000000;
            stab_cnt_r  <= 4'd0;
            irq_en_r    <= 1'b0;
        end else begin
            sync_meta_r <= switch_raw;
            sync_r      <= sync_meta_r;
            cand_r      <= cand_nxt_s;
            stable_r    <= stable_nxt_s;
            chg_r       <= chg_nxt_s;
            stab_cnt_r  <= cnt_nxt_s;
            irq_en_r    <= irq_en_nxt_s;
        end
    end

    // Read data is captured mid-cycle, so a simultaneous write lands only after the read.
    always_ff @(negedge scanclk or posedge scanrst) begin
        if (scanrst) begin
            rdata_r <= 16'h0000;
        end else if (rd_en_s) begin
            rdata_r <= reg_read(scanaddr, stable_r, chg_r, irq_en_r);
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign scanrdata = rdata_r;
    assign scan_irq  = irq_en_r & (|chg_r);

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Directed bench for switch_scan_ctrl with SAMPLE_DIV=4, STABLE_CNT=3.
module tb_switch_scan_ctrl;

    logic        scanclk    = 1'b0;
    logic        scanrst    = 1'b0;
    logic [23:0] switch_raw = 24'h000000;
    logic        scanctl    = 1'b0;
    logic        scanread   = 1'b0;
    logic        scanwrite  = 1'b0;
    logic [1:0]  scanaddr   = 2'b00;
    logic [15:0] scanwdata  = 16'h0000;
    logic [15:0] scanrdata;
    logic        scan_irq;

    int tests = 0;
    int fails = 0;
    int ecount;

    switch_scan_ctrl #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (3)
    ) dut (
        .scanclk    (scanclk),
        .scanrst    (scanrst),
        .switch_raw (switch_raw),
        .scanctl    (scanctl),
        .scanread   (scanread),
        .scanwrite  (scanwrite),
        .scanaddr   (scanaddr),
        .scanwdata  (scanwdata),
        .scanrdata  (scanrdata),
        .scan_irq   (scan_irq)
    );

    always #5 scanclk = ~scanclk;

    // Edges since reset release; debounce ticks are consumed on multiples of 4.
    always @(posedge scanclk or posedge scanrst) begin
        if (scanrst) ecount <= 0;
        else         ecount <= ecount + 1;
    end

    task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
        @(posedge scanclk); #1;
        scanctl = 1'b1; scanwrite = 1'b1; scanaddr = addr; scanwdata = data;
        @(posedge scanclk); #1;
        scanctl = 1'b0; scanwrite = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [15:0] data);
        @(posedge scanclk); #1;
        scanctl = 1'b1; scanread = 1'b1; scanaddr = addr;
        @(negedge scanclk); #1;
        data = scanrdata;
        scanctl = 1'b0; scanread = 1'b0;
    endtask

    // Leaves the bench 1 time unit after an edge that consumed a tick.
    task automatic align_tick();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge scanclk); #1;
            if (ecount % 4 == 0) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL align_tick: ecount=%0d not tick-aligned within 8 cycles", ecount);
        end
    endtask

    function automatic logic bounce_lvl(input int j);
        if (j >= 20) return 1'b1;
        return ((j / 3) % 2) == 0;
    endfunction

    task automatic test_reset();
        logic [15:0] d;
        #1 scanrst = 1'b1;
        #2;
        tests++;
        if (scanrdata !== 16'h0000 || scan_irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rdata=%h irq=%b expected 0000/0", scanrdata, scan_irq);
        end
        @(negedge scanclk) scanrst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), d);
            tests++;
            if (d !== 16'h0000) begin
                fails++;
                $display("FAIL reset_reg%0d: got %h expected 0000", a, d);
            end
        end
    endtask

    task automatic test_accept();
        logic [15:0] d;
        @(negedge scanclk);
        scanrst = 1'b1;
        switch_raw = 24'hA51234;
        scanctl = 1'b1; scanread = 1'b1; scanaddr = 2'b00;
        @(posedge scanclk);
        @(negedge scanclk) scanrst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge scanclk); @(negedge scanclk); #1;
            if (k == 15) begin
                tests++;
                if (scanrdata !== 16'h0000) begin
                    fails++;
                    $display("FAIL accept_early: edge15 got %h expected 0000", scanrdata);
                end
            end
            if (k == 16) begin
                tests++;
                if (scanrdata !== 16'h1234) begin
                    fails++;
                    $display("FAIL accept_edge16: got %h expected 1234", scanrdata);
                end
            end
        end
        scanctl = 1'b0; scanread = 1'b0;
        bus_read(2'b10, d);
        tests++;
        if (d !== 16'h00A5) begin fails++; $display("FAIL stab_hi: got %h expected 00a5", d); end
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h1234) begin fails++; $display("FAIL chg_lo: got %h expected 1234", d); end
        bus_read(2'b11, d);
        tests++;
        if (d !== 16'h00A5 || scan_irq !== 1'b0) begin
            fails++;
            $display("FAIL ctrl_hi: got %h irq=%b expected 00a5/0", d, scan_irq);
        end
        bus_write(2'b01, 16'hFFFF);
        bus_write(2'b11, 16'h00FF);
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h0000) begin fails++; $display("FAIL clear_lo: got %h expected 0000", d); end
        bus_read(2'b11, d);
        tests++;
        if (d !== 16'h0000) begin fails++; $display("FAIL clear_hi: got %h expected 0000", d); end
    endtask

    task automatic test_bounce();
        logic [15:0] d;
        int bad = 0;
        scanctl = 1'b1; scanread = 1'b1; scanaddr = 2'b00;
        align_tick();
        switch_raw[0] = bounce_lvl(0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge scanclk); #1;
            switch_raw[0] = bounce_lvl(k);
            @(negedge scanclk); #1;
            if (k < 36 && scanrdata !== 16'h1234) bad++;
            if (k == 36) begin
                tests++;
                if (scanrdata !== 16'h1235) begin
                    fails++;
                    $display("FAIL bounce_accept: edge36 got %h expected 1235", scanrdata);
                end
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bounce_hold: %0d early changes, expected 0", bad);
        end
        scanctl = 1'b0; scanread = 1'b0;
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h0001) begin fails++; $display("FAIL bounce_chg: got %h expected 0001", d); end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        bus_write(2'b01, 16'hFFFF);
        bus_write(2'b11, 16'h8000);
        tests++;
        if (scan_irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b expected 0", scan_irq); end
        switch_raw = 24'hB51235;
        repeat (24) @(posedge scanclk);
        #1;
        tests++;
        if (scan_irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b expected 1", scan_irq); end
        bus_read(2'b11, d);
        tests++;
        if (d !== 16'h8010) begin fails++; $display("FAIL irq_ctrl: got %h expected 8010", d); end
        bus_write(2'b11, 16'h0010);
        tests++;
        if (scan_irq !== 1'b0) begin fails++; $display("FAIL irq_fall: got %b expected 0", scan_irq); end
        bus_read(2'b11, d);
        tests++;
        if (d !== 16'h0000) begin fails++; $display("FAIL irq_cleared: got %h expected 0000", d); end
    endtask

    task automatic test_set_clear_collision();
        logic [15:0] d;
        logic [15:0] rw;
        align_tick();
        switch_raw = 24'hB5123D;
        repeat (15) @(posedge scanclk);
        #1;
        scanctl = 1'b1; scanwrite = 1'b1; scanaddr = 2'b01; scanwdata = 16'h0008;
        @(posedge scanclk); #1;
        scanctl = 1'b0; scanwrite = 1'b0;
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h0008) begin fails++; $display("FAIL set_wins: got %h expected 0008", d); end
        @(posedge scanclk); #1;
        scanctl = 1'b1; scanread = 1'b1; scanwrite = 1'b1; scanaddr = 2'b01; scanwdata = 16'hFFFF;
        @(negedge scanclk); #1;
        rw = scanrdata;
        @(posedge scanclk); #1;
        scanctl = 1'b0; scanread = 1'b0; scanwrite = 1'b0;
        tests++;
        if (rw !== 16'h0008) begin fails++; $display("FAIL rw_prewrite: got %h expected 0008", rw); end
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h0000) begin fails++; $display("FAIL rw_cleared: got %h expected 0000", d); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        switch_raw = 24'hB5123C;
        repeat (24) @(posedge scanclk);
        bus_write(2'b11, 16'h8000);
        tests++;
        if (scan_irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq: got %b expected 1", scan_irq); end
        scanctl = 1'b1; scanread = 1'b1; scanaddr = 2'b00;
        align_tick();
        switch_raw = 24'hB5123D;
        repeat (9) @(posedge scanclk);
        #2;
        scanrst = 1'b1;
        #1;
        tests++;
        if (scanrdata !== 16'h0000 || scan_irq !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: rdata=%h irq=%b expected 0000/0", scanrdata, scan_irq);
        end
        @(posedge scanclk);
        @(negedge scanclk) scanrst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge scanclk); @(negedge scanclk); #1;
            if (k == 15) begin
                tests++;
                if (scanrdata !== 16'h0000) begin
                    fails++;
                    $display("FAIL stale_accept: edge15 got %h expected 0000", scanrdata);
                end
            end
            if (k == 16) begin
                tests++;
                if (scanrdata !== 16'h123D) begin
                    fails++;
                    $display("FAIL post_reset_accept: got %h expected 123d", scanrdata);
                end
            end
        end
        scanctl = 1'b0; scanread = 1'b0;
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h123D) begin fails++; $display("FAIL post_reset_chg: got %h expected 123d", d); end
    endtask

    task automatic test_no_select();
        logic [15:0] d;
        bus_read(2'b10, d);
        tests++;
        if (d !== 16'h00B5) begin fails++; $display("FAIL ns_stab_hi: got %h expected 00b5", d); end
        scanctl = 1'b0; scanread = 1'b1; scanaddr = 2'b00;
        repeat (3) @(negedge scanclk);
        #1;
        tests++;
        if (scanrdata !== 16'h00B5) begin fails++; $display("FAIL ns_hold: got %h expected 00b5", scanrdata); end
        scanread = 1'b0;
        @(posedge scanclk); #1;
        scanwrite = 1'b1; scanaddr = 2'b01; scanwdata = 16'hFFFF;
        @(posedge scanclk); #1;
        scanaddr = 2'b11; scanwdata = 16'h80FF;
        @(posedge scanclk); #1;
        scanwrite = 1'b0;
        bus_write(2'b00, 16'hFFFF);
        bus_write(2'b10, 16'hFFFF);
        bus_read(2'b01, d);
        tests++;
        if (d !== 16'h123D) begin fails++; $display("FAIL ns_chg_lo: got %h expected 123d", d); end
        bus_read(2'b11, d);
        tests++;
        if (d !== 16'h00B5 || scan_irq !== 1'b0) begin
            fails++;
            $display("FAIL ns_ctrl_hi: got %h irq=%b expected 00b5/0", d, scan_irq);
        end
        bus_read(2'b00, d);
        tests++;
        if (d !== 16'h123D) begin fails++; $display("FAIL ro_stab_lo: got %h expected 123d", d); end
        bus_read(2'b10, d);
        tests++;
        if (d !== 16'h00B5) begin fails++; $display("FAIL ro_stab_hi: got %h expected 00b5", d); end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_bounce();
        test_irq();
        test_set_clear_collision();
        test_reset_mid();
        test_no_select();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
